// File: rtl/ahb_apb_pkg.sv
// Shared encodings for the AHB side of the AHB-to-APB bridge.
package ahb_apb_pkg;

    // AHB transfer types
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // AHB responses
    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    // Transfer sizes the APB side can accept
    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // One-hot APB slave selects
    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_SLV0 = 3'b001;
    localparam logic [2:0] SEL_SLV1 = 3'b010;
    localparam logic [2:0] SEL_SLV2 = 3'b100;

    // Two-cycle AHB ERROR response tracker
    typedef enum logic [1:0] {
        ERR_OKAY = 2'b00,
        ERR_ERR1 = 2'b01,
        ERR_ERR2 = 2'b10
    } err_state_t;

endpackage

// File: rtl/ahb_slave_if_if.sv
// Bus bundle between the AHB master side and the bridge's AHB front end.
interface ahb_slave_if_if;
    import ahb_apb_pkg::*;

    logic        Hwrite;
    logic        Hreadyin;
    logic [1:0]  Htrans;
    logic [2:0]  Hsize;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic [31:0] Prdata;
    logic        valid;
    logic [31:0] Haddr1;
    logic [31:0] Haddr2;
    logic [31:0] Hwdata1;
    logic [31:0] Hwdata2;
    logic        Hwritereg;
    logic [2:0]  tempselx;
    logic [31:0] Hrdata;
    logic [1:0]  Hresp;
    logic        Hready_err;

    modport master (
        output Hwrite, Hreadyin, Htrans, Hsize, Haddr, Hwdata, Prdata,
        input  valid, Haddr1, Haddr2, Hwdata1, Hwdata2, Hwritereg,
               tempselx, Hrdata, Hresp, Hready_err
    );

    modport slave (
        input  Hwrite, Hreadyin, Htrans, Hsize, Haddr, Hwdata, Prdata,
        output valid, Haddr1, Haddr2, Hwdata1, Hwdata2, Hwritereg,
               tempselx, Hrdata, Hresp, Hready_err
    );

endinterface

// File: rtl/ahb_addr_decoder.sv
// Combinational slave decode and legality check for an AHB address phase.
module ahb_addr_decoder
    import ahb_apb_pkg::*;
#(
    parameter logic [31:0] SLV0_BASE     = 32'h8000_0000,
    parameter logic [31:0] SLV1_BASE     = 32'h8400_0000,
    parameter logic [31:0] SLV2_BASE     = 32'h8800_0000,
    parameter int          SLV_SIZE_LOG2 = 26
) (
    input  logic [31:0] Haddr,
    input  logic [2:0]  Hsize,
    output logic [2:0]  tempselx,
    output logic        legal
);

    localparam logic [2:0][31:0] SLV_BASES  = {SLV2_BASE, SLV1_BASE, SLV0_BASE};
    localparam logic [2:0][2:0]  SEL_ONEHOT = {SEL_SLV2, SEL_SLV1, SEL_SLV0};

    logic [2:0] hit;
    logic       aligned;
    // Offset bits inside a window only matter for alignment (bits 1:0)
    logic       unused_addr_bits;

    assign unused_addr_bits = ^Haddr[SLV_SIZE_LOG2-1:2];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_hit
            assign hit[gi] = (Haddr[31:SLV_SIZE_LOG2] == SLV_BASES[gi][31:SLV_SIZE_LOG2]);
        end
    endgenerate

    // Merge window hits into the one-hot select
    always_comb begin
        tempselx = SEL_NONE;
        for (int i = 0; i < 3; i++) begin
            if (hit[i]) begin
                tempselx = tempselx | SEL_ONEHOT[i];
            end
        end
    end

    // Natural alignment for byte/half/word; wider sizes never fit the APB side
    always_comb begin
        aligned = 1'b0;
        case (Hsize)
            HSIZE_BYTE: aligned = 1'b1;
            HSIZE_HALF: aligned = ~Haddr[0];
            HSIZE_WORD: aligned = (Haddr[1:0] == 2'b00);
            default:    aligned = 1'b0;
        endcase
    end

    assign legal = (tempselx != SEL_NONE) && aligned;

endmodule

// File: rtl/ahb_slave_if.sv
// AHB front end of the AHB-to-APB bridge: qualifies transfers, pipelines
// address/data/direction for the APB controller, and answers illegal
// transfers with a two-cycle AHB ERROR response.
module ahb_slave_if
    import ahb_apb_pkg::*;
#(
    parameter logic [31:0] SLV0_BASE     = 32'h8000_0000,
    parameter logic [31:0] SLV1_BASE     = 32'h8400_0000,
    parameter logic [31:0] SLV2_BASE     = 32'h8800_0000,
    parameter int          SLV_SIZE_LOG2 = 26
) (
    input  logic             Hclk,
    input  logic             Hresetn,
    ahb_slave_if_if.slave    bus
);

    logic [31:0] haddr1_reg;
    logic [31:0] haddr2_reg;
    logic [31:0] hwdata1_reg;
    logic [31:0] hwdata2_reg;
    logic        hwrite_reg;
    err_state_t  err_state_reg;
    err_state_t  err_state_next;
    logic        active;
    logic        legal;
    logic        illegal_req;

    ahb_addr_decoder #(
        .SLV0_BASE     (SLV0_BASE),
        .SLV1_BASE     (SLV1_BASE),
        .SLV2_BASE     (SLV2_BASE),
        .SLV_SIZE_LOG2 (SLV_SIZE_LOG2)
    ) u_decoder (
        .Haddr    (bus.Haddr),
        .Hsize    (bus.Hsize),
        .tempselx (bus.tempselx),
        .legal    (legal)
    );

    // Only NONSEQ and SEQ carry a real transfer
    always_comb begin
        active = 1'b0;
        case (bus.Htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  active = 1'b0;
            default:                   active = 1'b0;
        endcase
    end

    assign illegal_req = bus.Hreadyin & active & ~legal;

    // ERR1 is the stalled cycle of the error response; no new transfer is
    // accepted there, but ERR2 completes and accepts the next address phase.
    assign bus.valid  = Hresetn & bus.Hreadyin & active & legal & (err_state_reg != ERR_ERR1);
    assign bus.Hrdata = bus.Prdata;

    // Address/data/direction pipeline; holds whenever the bus is stalled
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            haddr1_reg  <= '0;
            haddr2_reg  <= '0;
            hwdata1_reg <= '0;
            hwdata2_reg <= '0;
            hwrite_reg  <= 1'b0;
        end else if (bus.Hreadyin) begin
            haddr1_reg  <= bus.Haddr;
            haddr2_reg  <= haddr1_reg;
            hwdata1_reg <= bus.Hwdata;
            hwdata2_reg <= hwdata1_reg;
            hwrite_reg  <= bus.Hwrite;
        end
    end

    assign bus.Haddr1    = haddr1_reg;
    assign bus.Haddr2    = haddr2_reg;
    assign bus.Hwdata1   = hwdata1_reg;
    assign bus.Hwdata2   = hwdata2_reg;
    assign bus.Hwritereg = hwrite_reg;

    // Error FSM state register
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            err_state_reg <= ERR_OKAY;
        end else begin
            err_state_reg <= err_state_next;
        end
    end

    // Error FSM next state and response outputs
    always_comb begin
        err_state_next = err_state_reg;
        bus.Hresp      = HRESP_OKAY;
        bus.Hready_err = 1'b1;
        case (err_state_reg)
            ERR_OKAY: begin
                if (illegal_req) begin
                    err_state_next = ERR_ERR1;
                end
            end
            ERR_ERR1: begin
                bus.Hresp      = HRESP_ERROR;
                bus.Hready_err = 1'b0;
                err_state_next = ERR_ERR2;
            end
            ERR_ERR2: begin
                bus.Hresp      = HRESP_ERROR;
                err_state_next = illegal_req ? ERR_ERR1 : ERR_OKAY;
            end
            default: begin
                err_state_next = ERR_OKAY;
            end
        endcase
    end

endmodule
